// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH = 32;

  // Last value of the shared 6-bit iteration counter (32 iterations).
  localparam logic [5:0] ITER_LAST = 6'd31;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_abs.sv
// Two's-complement conditional negation with sign extraction.
// With neg_i tied to the operand's sign bit this yields the magnitude.
// With neg_i driven by a result-sign flag it applies the final sign fix-up.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o
);

  assign sign_o = val_i[WIDTH-1];
  assign mag_o  = neg_i ? -val_i : val_i;

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on
// magnitudes) feeding the HI and LO registers.
//
// Handshake: start is honoured only in IDLE or DONE (busy=0). The result
// appears on hi/lo in the cycle where done pulses high for one cycle. It then
// holds until the next completed operation. div_zero pulses with done on a
// zero divisor, and in that case hi/lo keep their old contents.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);
  import muldiv_pkg::*;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             dz_q, dz_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  // acc: Booth accumulator (one guard bit so -M of the most negative value
  // cannot overflow); for DIV its low half holds the partial remainder.
  logic [WIDTH:0]   acc_q, acc_d;
  // q: Booth multiplier shift register, or DIV dividend/quotient.
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  // m: sign-extended multiplicand for MULT, zero-extended |b| for DIV.
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Magnitude units: operand magnitudes at start, sign fix-up in FIX.
  logic             in_fix;
  logic [WIDTH-1:0] a_val, b_val, a_mag, b_mag;
  logic             a_neg, b_neg, a_sign, b_sign;

  assign in_fix = (state_q == FIX);
  assign a_val  = in_fix ? q_q : a;
  assign a_neg  = in_fix ? (sa_q ^ sb_q) : a[WIDTH-1];
  assign b_val  = in_fix ? acc_q[WIDTH-1:0] : b;
  assign b_neg  = in_fix ? sa_q : b[WIDTH-1];

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val_i  (a_val),
    .neg_i  (a_neg),
    .mag_o  (a_mag),
    .sign_o (a_sign)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val_i  (b_val),
    .neg_i  (b_neg),
    .mag_o  (b_mag),
    .sign_o (b_sign)
  );

  // One Booth step: add/subtract M by {Q[0], q-1}, then arithmetic shift right.
  logic [WIDTH:0]   mul_sum, mul_acc_n;
  logic [WIDTH-1:0] mul_q_n;

  always_comb begin
    case ({q_q[0], qm1_q})
      2'b10:   mul_sum = acc_q - m_q;
      2'b01:   mul_sum = acc_q + m_q;
      default: mul_sum = acc_q;
    endcase
    mul_acc_n = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
    mul_q_n   = {mul_sum[0], q_q[WIDTH-1:1]};
  end

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic [WIDTH-1:0] div_rem_n, div_q_n;
  logic             unused_trial_bit;

  always_comb begin
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {1'b0, m_q};
    if (div_trial[WIDTH+1]) begin
      div_rem_n = div_shift[WIDTH-1:0];
      div_q_n   = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      div_rem_n = div_trial[WIDTH-1:0];
      div_q_n   = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  // The bit above the remainder is zero whenever the trial result is kept.
  assign unused_trial_bit = div_trial[WIDTH];

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dz_d    = dz_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          op_d  = op;
          cnt_d = 6'd0;
          acc_d = '0;
          qm1_d = 1'b0;
          sa_d  = a_sign;
          sb_d  = b_sign;
          dz_d  = 1'b0;
          if (op == OP_DIV) begin
            q_d = a_mag;
            m_d = {1'b0, b_mag};
            if (b == '0) begin
              state_d = DONE;
              dz_d    = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            q_d     = a;
            m_d     = {b[WIDTH-1], b};
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q == OP_MULT) begin
          acc_d = mul_acc_n;
          q_d   = mul_q_n;
          qm1_d = q_q[0];
          if (cnt_q == ITER_LAST) begin
            state_d = DONE;
            hi_d    = mul_acc_n[WIDTH-1:0];
            lo_d    = mul_q_n;
          end
        end else begin
          acc_d = {1'b0, div_rem_n};
          q_d   = div_q_n;
          if (cnt_q == ITER_LAST) state_d = FIX;
        end
      end
      FIX: begin
        // Quotient negated on differing signs, remainder follows the dividend.
        hi_d    = b_mag;
        lo_d    = a_mag;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      dz_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q == RUN) || (state_q == FIX);
  assign done      = (state_q == DONE);
  assign div_zero  = (state_q == DONE) && dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: hand-computed MULT/DIV results, latencies,
// divide by zero, reset abort, ignored start and back-to-back start.
module tb_hilo_muldiv;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Clock generation.
  always #5 clock = ~clock;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start in cycle 0; returns in cycle 1 with operands scrambled.
  task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1357_9BDF;
  endtask

  // Count cycles until done, bounded; n0 is the current cycle number.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int n;
    launch(o, x, y);
    chk({tag, " busy c1"}, busy, 1'b1);
    wait_done(1, n);
    chk({tag, " latency"}, n, (o == 1'b1) ? 34 : 33);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    chk({tag, " busy at done"}, busy, 1'b0);
    chk({tag, " div_zero"}, div_zero, 1'b0);
    tick();
    chk({tag, " done pulse width"}, done, 1'b0);
    chk({tag, " hi hold"}, hi, exp_hi);
  endtask

  initial begin
    int n;

    // Reset state.
    reset = 1'b0;
    tick();
    tick();
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst div_zero", div_zero, 1'b0);
    chk("rst state", dbg_state, 2'd0);
    reset = 1'b1;
    tick();

    // Signed multiplies.
    do_op("mul 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    do_op("mul max*2", 1'b0, 32'h7FFF_FFFF, 32'd2, 32'h0, 32'hFFFF_FFFE);

    // Signed divides.
    do_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    do_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // 1682 / 32 = 52 r 18 leaves hi=0x12, lo=0x34 for the div-zero test.
    do_op("div 1682/32", 1'b1, 32'd1682, 32'd32, 32'h12, 32'h34);

    // Divide by zero: done in cycle 1, hi/lo unchanged, busy never set.
    launch(1'b1, 32'd5, 32'd0);
    chk("dz done", done, 1'b1);
    chk("dz flag", div_zero, 1'b1);
    chk("dz busy", busy, 1'b0);
    chk("dz hi", hi, 32'h12);
    chk("dz lo", lo, 32'h34);
    tick();
    chk("dz done pulse", done, 1'b0);
    chk("dz flag pulse", div_zero, 1'b0);

    // Reset in cycle 10 of a multiply aborts it.
    launch(1'b0, 32'h0000_1234, 32'h0000_0010);
    repeat (9) tick();
    chk("abort busy c10", busy, 1'b1);
    reset = 1'b0;
    tick();
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    chk("abort state", dbg_state, 2'd0);
    reset = 1'b1;
    tick();
    do_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);

    // A start in cycle 5 is ignored; the first result is still 3*5.
    launch(1'b0, 32'd3, 32'd5);
    repeat (4) tick();
    op    = 1'b1;
    a     = 32'd9;
    b     = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ignored start busy", busy, 1'b1);
    chk("ignored start dz", div_zero, 1'b0);
    wait_done(6, n);
    chk("ignore latency", n, 33);
    chk("ignore hi", hi, 32'h0);
    chk("ignore lo", lo, 32'd15);

    // A start in the DONE cycle is accepted: -2*6 = -12.
    op    = 1'b0;
    a     = 32'hFFFF_FFFE;
    b     = 32'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b busy", busy, 1'b1);
    chk("b2b done low", done, 1'b0);
    chk("b2b hi hold", hi, 32'h0);
    chk("b2b lo hold", lo, 32'd15);
    wait_done(1, n);
    chk("b2b latency", n, 33);
    chk("b2b hi", hi, 32'hFFFF_FFFF);
    chk("b2b lo", lo, 32'hFFFF_FFF4);
    tick();
    chk("b2b done pulse", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
